// File: rtl/mux_arb.sv
// Multi-channel mux with fixed-select or round-robin arbitration feeding a
// single registered output stage with valid/ready handshaking.
module mux_arb #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SW       = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SW-1:0]             sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SW-1:0]             out_chan,
  input  logic                      out_ready
);

  logic                can_load;
  logic                xfer;
  logic                found;
  logic [CHANNELS-1:0] grant;
  logic [SW-1:0]       gidx;
  logic [SW:0]         cand;
  logic [WIDTH-1:0]    gdata;
  logic [SW-1:0]       ptr;

  // Grant: one channel from sel in mode 0, first valid after ptr in mode 1.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = '0;
    if (mode == 1'b0) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (32'(sel) == i) begin
          grant[i] = 1'b1;
          gidx     = sel;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        cand = {1'b0, ptr} + (SW+1)'(k);
        if (cand >= (SW+1)'(CHANNELS)) cand = cand - (SW+1)'(CHANNELS);
        if (!found && in_valid[cand[SW-1:0]]) begin
          found                = 1'b1;
          grant[cand[SW-1:0]] = 1'b1;
          gidx                 = cand[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_load = !out_valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {CHANNELS{can_load}});
  assign xfer     = |(in_valid & in_ready);

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(CHANNELS - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_chan  <= gidx;
        if (mode) ptr <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: a 2-channel and a 3-channel instance.
module tb_mux_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_mode, a_oready, a_ovalid;
  logic [0:0] a_sel, a_ochan;
  logic [1:0] a_valid, a_ready;
  logic [7:0] a_data;
  logic [3:0] a_odata;

  logic        b_mode, b_oready, b_ovalid;
  logic [1:0]  b_sel, b_ochan;
  logic [2:0]  b_valid, b_ready;
  logic [11:0] b_data;
  logic [3:0]  b_odata;

  int total = 0;
  int bad   = 0;

  mux_arb #(.WIDTH(4), .CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel), .in_valid(a_valid),
    .in_data(a_data), .in_ready(a_ready), .out_valid(a_ovalid),
    .out_data(a_odata), .out_chan(a_ochan), .out_ready(a_oready)
  );

  mux_arb #(.WIDTH(4), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel), .in_valid(b_valid),
    .in_data(b_data), .in_ready(b_ready), .out_valid(b_ovalid),
    .out_data(b_odata), .out_chan(b_ochan), .out_ready(b_oready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [3:0] d, input logic c);
    chk({tag, ".valid"}, 64'(a_ovalid), 64'(v));
    chk({tag, ".data"},  64'(a_odata),  64'(d));
    chk({tag, ".chan"},  64'(a_ochan),  64'(c));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
    chk({tag, ".valid"}, 64'(b_ovalid), 64'(v));
    chk({tag, ".data"},  64'(b_odata),  64'(d));
    chk({tag, ".chan"},  64'(b_ochan),  64'(c));
  endtask

  initial begin
    rst = 1'b1;
    a_mode = 1'b0; a_sel = 1'b0; a_valid = 2'b00; a_data = 8'h00; a_oready = 1'b0;
    b_mode = 1'b0; b_sel = 2'd0; b_valid = 3'b000; b_data = 12'h000; b_oready = 1'b0;
    #2;
    chk_a("a_reset", 1'b0, 4'h0, 1'b0);
    chk("a_reset.in_ready", 64'(a_ready), 64'(2'b00));
    chk_b("b_reset", 1'b0, 4'h0, 2'd0);
    tick();
    rst = 1'b0;

    // Fixed select, sel=0 then sel=1
    a_valid = 2'b11; a_data = {4'b0010, 4'b0001}; a_oready = 1'b1;
    #1 chk("m0_sel0.in_ready", 64'(a_ready), 64'(2'b01));
    tick();
    chk_a("m0_sel0", 1'b1, 4'b0001, 1'b0);
    a_sel = 1'b1;
    #1 chk("m0_sel1.in_ready", 64'(a_ready), 64'(2'b10));
    tick();
    chk_a("m0_sel1", 1'b1, 4'b0010, 1'b1);

    // Backpressure holding 1111, then reload in the consuming cycle
    a_data = {4'b1111, 4'b0001};
    tick();
    chk_a("bp_load", 1'b1, 4'b1111, 1'b1);
    a_oready = 1'b0; a_data = {4'b0110, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.in_ready", 64'(a_ready), 64'(2'b00));
      tick();
      chk_a("bp_hold", 1'b1, 4'b1111, 1'b1);
    end
    a_oready = 1'b1;
    #1 chk("bp_release.in_ready", 64'(a_ready), 64'(2'b10));
    tick();
    chk_a("bp_reload", 1'b1, 4'b0110, 1'b1);

    // Granted but not valid: no transfer, output drains, data/chan hold
    a_sel = 1'b0; a_valid = 2'b10;
    #1 chk("novalid.in_ready", 64'(a_ready), 64'(2'b01));
    tick();
    chk_a("novalid_drain", 1'b0, 4'b0110, 1'b1);

    // Round robin; mode-0 traffic must not have moved ptr, so ch0 first
    a_mode = 1'b1; a_valid = 2'b11; a_data = {4'b1100, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr.in_ready", 64'(a_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick();
      if (i % 2 == 0) chk_a("rr_even", 1'b1, 4'b0011, 1'b0);
      else            chk_a("rr_odd",  1'b1, 4'b1100, 1'b1);
    end

    // Asynchronous reset with a held word
    a_mode = 1'b0; a_sel = 1'b0; a_data = {4'b1100, 4'b1010};
    tick();
    chk_a("pre_rst", 1'b1, 4'b1010, 1'b0);
    a_oready = 1'b0;
    rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 4'h0, 1'b0);
    chk("async_rst.in_ready", 64'(a_ready), 64'(2'b00));
    #2 rst = 1'b0;

    // First edge after reset already transfers
    a_oready = 1'b1; a_data = {4'b1100, 4'b0111};
    tick();
    chk_a("post_rst", 1'b1, 4'b0111, 1'b0);
    a_valid = 2'b00;

    // 3 channels: only ch2 valid, then wrap to ch0
    b_mode = 1'b1; b_oready = 1'b1; b_valid = 3'b100;
    b_data = {4'b0101, 4'b0010, 4'b0001};
    #1 chk("b_ch2.in_ready", 64'(b_ready), 64'(3'b100));
    tick();
    chk_b("b_ch2", 1'b1, 4'b0101, 2'd2);
    b_valid = 3'b011;
    #1 chk("b_wrap.in_ready", 64'(b_ready), 64'(3'b001));
    tick();
    chk_b("b_wrap", 1'b1, 4'b0001, 2'd0);
    #1 chk("b_next.in_ready", 64'(b_ready), 64'(3'b010));
    tick();
    chk_b("b_next", 1'b1, 4'b0010, 2'd1);

    // Out-of-range sel grants nothing
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111;
    #1 chk("b_sel3.in_ready", 64'(b_ready), 64'(3'b000));
    tick();
    chk("b_sel3.valid1", 64'(b_ovalid), 64'(1'b0));
    chk("b_sel3.in_ready2", 64'(b_ready), 64'(3'b000));
    tick();
    chk("b_sel3.valid2", 64'(b_ovalid), 64'(1'b0));

    // Mode 0 on ch2 leaves ptr at 1, so round robin next picks ch2
    b_sel = 2'd2;
    tick();
    chk_b("b_m0_ch2", 1'b1, 4'b0101, 2'd2);
    b_mode = 1'b1; b_data = {4'b1001, 4'b0010, 4'b0001};
    #1 chk("b_ptr_kept.in_ready", 64'(b_ready), 64'(3'b100));
    tick();
    chk_b("b_ptr_kept", 1'b1, 4'b1001, 2'd2);
    tick();
    chk_b("b_rr_after", 1'b1, 4'b0001, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel; legal range 1..64.
REQ-002 Parameter CHANNELS, default 2, number of input channels; legal range 2..16.
REQ-003 Parameter SW = max(1, clog2(CHANNELS)), derived; width of sel and out_chan.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mode  input  1  0 = fixed select (channel given by sel), 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used when mode = 0.
REQ-008 in_valid  input  CHANNELS  per-channel data valid.
REQ-009 in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  per-channel accept strobe.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_chan  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 The block SHALL contain one output register stage: out_valid, out_data and out_chan are flops, and no input reaches any output combinationally except through in_ready.
REQ-016 Definition: can_load = !out_valid || out_ready.
REQ-017 Definition: input transfer on channel i = in_valid[i] && in_ready[i]; output transfer = out_valid && out_ready.
REQ-018 Mode 0 eligibility: only channel sel is eligible. If sel >= CHANNELS, no channel SHALL be eligible.
REQ-019 Mode 1 eligibility: the eligible channel SHALL be the first channel with in_valid = 1, searching from index (ptr+1) mod CHANNELS upward with wrap-around.
REQ-020 grant is one-hot or zero. in_ready[i] SHALL equal grant[i] && can_load, and SHALL be independent of in_valid[i] in mode 0.
REQ-021 On an input transfer, the next cycle SHALL show out_valid = 1, out_data = the granted channel's word and out_chan = its index. Latency is 1 cycle.
REQ-022 Output transfer with no input transfer in the same cycle: out_valid SHALL clear next cycle, and out_data/out_chan SHALL hold their values.
REQ-023 Simultaneous output and input transfer: the register SHALL reload, giving 1 word per cycle sustained throughput with no bubble.
REQ-024 Backpressure (out_valid && !out_ready): out_data and out_chan SHALL be stable, all in_ready SHALL be 0, and no input is consumed.
REQ-025 ptr (SW bits) SHALL update to the granted index on every input transfer in mode 1 only. Mode 0 transfers SHALL leave ptr unchanged.
REQ-026 Round-robin fairness: with all CHANNELS requesting continuously and out_ready = 1, each channel SHALL be granted exactly once per CHANNELS consecutive transfers.
REQ-027 A change of mode or sel SHALL affect only the grant computed in that cycle. A word already in the output register is unaffected.
REQ-028 A channel whose in_valid is 0 SHALL never be transferred, even if it is granted in mode 0.

Reset
REQ-029 While rst = 1, the block SHALL immediately drive out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1 (so channel 0 has first priority), and all in_ready = 0.
REQ-030 Reset asserted mid-operation SHALL discard any held word without it being counted as transferred.
REQ-031 The first rising clk edge after rst deasserts SHALL already permit an input transfer.

Verification (WIDTH=4, CHANNELS=2 unless noted)
REQ-032 Mode 0, sel=0, in_data ch0=0001, ch1=0010, both valid, out_ready=1 -> next cycle out_valid=1, out_data=0001, out_chan=0; then sel=1 -> out_data=0010, out_chan=1.
REQ-033 Mode 0, sel=1, ch1=1111 valid, out_ready=0 for 3 cycles -> out_data stays 1111, in_ready=00; out_ready=1 -> word consumed, new ch1 word loaded in the same cycle.
REQ-034 Mode 1 after reset, both channels valid (ch0=0011, ch1=1100), out_ready=1 for 4 cycles -> out_chan sequence 0,1,0,1 and out_data sequence 0011,1100,0011,1100.
REQ-035 Mode 1, CHANNELS=3, only ch2 valid (word 0101) -> ch2 granted and out_data=0101; then ch0 and ch1 valid -> ch0 granted next (wrap-around from ptr=2).
REQ-036 Holding out_valid=1, out_data=1010: assert rst for one half-cycle -> out_valid=0, out_data=0000, out_chan=0 immediately, with no clock edge required.
REQ-037 Mode 0, CHANNELS=3, sel=3 with all channels valid -> in_ready=000 and out_valid stays 0.
